// File: rtl/cpu_pipe_pkg.sv
// Shared state encoding and reset value for the elastic pipeline stage.
package cpu_pipe_pkg;
  typedef enum logic [1:0] {PS_EMPTY, PS_ONE, PS_TWO} pipe_state_t;
  localparam logic PIPE_RST_DATA = '0;
endpackage

// File: rtl/pipe_load_reg.sv
// Data register with synchronous reset and load enable.
module pipe_load_reg
  import cpu_pipe_pkg::*;
#(
  parameter int size = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_load,
  input  logic [size-1:0] i_d,
  output logic [size-1:0] o_q
);
  logic [size-1:0] r_q;

  always_ff @(posedge clk) begin
    if (reset)       r_q <= {size{PIPE_RST_DATA}};
    else if (i_load) r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid pipeline stage: registered in_ready, full throughput, sync flush.
module pipe_skid_stage
  import cpu_pipe_pkg::*;
#(
  parameter int size = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [size-1:0] in_data,
  output logic            in_ready,
  output logic            out_valid,
  output logic [size-1:0] out_data,
  input  logic            out_ready
);
  pipe_state_t     r_state, w_nxt;
  logic            r_in_ready;
  logic            w_in_xfer, w_out_xfer;
  logic            w_ld_main, w_ld_skid, w_main_from_skid;
  logic [size-1:0] w_main_d, w_skid_q;

  assign w_in_xfer  = in_valid & r_in_ready;
  assign w_out_xfer = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= PS_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_nxt;
      r_in_ready <= (w_nxt != PS_TWO);
    end
  end

  // Flush wins over every transition and blocks all data loads.
  always_comb begin
    w_nxt            = r_state;
    w_ld_main        = 1'b0;
    w_ld_skid        = 1'b0;
    w_main_from_skid = 1'b0;
    if (flush) begin
      w_nxt = PS_EMPTY;
    end else begin
      unique case (r_state)
        PS_EMPTY: if (w_in_xfer) begin
          w_nxt     = PS_ONE;
          w_ld_main = 1'b1;
        end
        PS_ONE: begin
          if (w_in_xfer && !w_out_xfer) begin
            w_nxt     = PS_TWO;
            w_ld_skid = 1'b1;
          end else if (w_in_xfer && w_out_xfer) begin
            w_ld_main = 1'b1;
          end else if (w_out_xfer) begin
            w_nxt = PS_EMPTY;
          end
        end
        PS_TWO: if (w_out_xfer) begin
          w_nxt            = PS_ONE;
          w_ld_main        = 1'b1;
          w_main_from_skid = 1'b1;
        end
        default: w_nxt = PS_EMPTY;
      endcase
    end
  end

  assign w_main_d = w_main_from_skid ? w_skid_q : in_data;

  pipe_load_reg #(.size(size)) u_main (
    .clk(clk), .reset(reset), .i_load(w_ld_main), .i_d(w_main_d), .o_q(out_data)
  );

  pipe_load_reg #(.size(size)) u_skid (
    .clk(clk), .reset(reset), .i_load(w_ld_skid), .i_d(in_data), .o_q(w_skid_q)
  );

  assign out_valid = (r_state != PS_EMPTY);
  assign in_ready  = r_in_ready;

  // Upstream must hold a stalled word steady (it may withdraw it).
  a_in_stable: assert property (@(posedge clk) disable iff (reset)
    (in_valid && !in_ready && !flush) |=> (!in_valid || $stable(in_data)));
endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed table plus hand-written corner sequences for pipe_skid_stage.
module tb_pipe_skid_stage;
  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [63:0] in_data, out_data;
  int          n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  pipe_skid_stage #(.size(64)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  typedef struct {
    logic        rst, fl, iv;
    logic [63:0] d;
    logic        ordy;
    logic        ev;
    logic [63:0] ed;
    logic        eir;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Apply inputs for one cycle, then check outputs just after the edge.
  task automatic step(input string tag, input logic rst, input logic fl, input logic iv,
                      input logic [63:0] d, input logic ordy,
                      input logic ev, input logic [63:0] ed, input logic eir);
    reset = rst; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
    @(posedge clk); #1;
    chk({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, ev});
    chk({tag, ".out_data"},  out_data, ed);
    chk({tag, ".in_ready"},  {63'd0, in_ready}, {63'd0, eir});
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    //            rst   fl    iv    data   ordy  ev    edata  eir
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 64'hAA, 1'b0, 1'b0, 64'h0,  1'b1};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 64'h0,  1'b0, 1'b0, 64'h0,  1'b1};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 64'h1,  1'b1, 1'b1, 64'h1,  1'b1};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 64'h2,  1'b1, 1'b1, 64'h2,  1'b1};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 64'h3,  1'b1, 1'b1, 64'h3,  1'b1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 64'h0,  1'b1, 1'b0, 64'h3,  1'b1};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 64'h10, 1'b0, 1'b1, 64'h10, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 64'h11, 1'b0, 1'b1, 64'h10, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 64'h12, 1'b0, 1'b1, 64'h10, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 64'h12, 1'b1, 1'b1, 64'h11, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 64'h12, 1'b1, 1'b1, 64'h12, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 64'h12, 1'b1, 1'b0, 64'h12, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 64'h30, 1'b0, 1'b1, 64'h30, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 64'h31, 1'b1, 1'b1, 64'h31, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 64'h0,  1'b0, 1'b1, 64'h31, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 64'h0,  1'b1, 1'b0, 64'h31, 1'b1};

    @(negedge clk);
    for (int i = 0; i < 16; i++)
      step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].d,
           vecs[i].ordy, vecs[i].ev, vecs[i].ed, vecs[i].eir);

    // Flush from TWO with a same-cycle offer: everything discarded.
    step("fl_a", 1'b0, 1'b0, 1'b1, 64'h20, 1'b0, 1'b1, 64'h20, 1'b1);
    step("fl_b", 1'b0, 1'b0, 1'b1, 64'h21, 1'b0, 1'b1, 64'h20, 1'b0);
    step("fl_c", 1'b0, 1'b1, 1'b1, 64'h22, 1'b0, 1'b0, 64'h20, 1'b1);
    step("fl_d", 1'b0, 1'b0, 1'b0, 64'h0,  1'b1, 1'b0, 64'h20, 1'b1);
    step("fl_e", 1'b0, 1'b0, 1'b0, 64'h0,  1'b1, 1'b0, 64'h20, 1'b1);
    step("fl_f", 1'b0, 1'b0, 1'b1, 64'h23, 1'b1, 1'b1, 64'h23, 1'b1);
    // Flush in ONE with a same-cycle delivery still empties the stage.
    step("fl_g", 1'b0, 1'b1, 1'b0, 64'h0,  1'b1, 1'b0, 64'h23, 1'b1);

    // Reset while TWO, then a fresh word with 1-cycle latency.
    step("rs_a", 1'b0, 1'b0, 1'b1, 64'h38, 1'b0, 1'b1, 64'h38, 1'b1);
    step("rs_b", 1'b0, 1'b0, 1'b1, 64'h39, 1'b0, 1'b1, 64'h38, 1'b0);
    step("rs_c", 1'b1, 1'b0, 1'b0, 64'h0,  1'b0, 1'b0, 64'h0,  1'b1);
    step("rs_d", 1'b0, 1'b0, 1'b1, 64'h40, 1'b1, 1'b1, 64'h40, 1'b1);
    step("rs_e", 1'b0, 1'b0, 1'b0, 64'h0,  1'b1, 1'b0, 64'h40, 1'b1);

    // Skid entry must have been cleared by reset: fill TWO, drain, check order.
    step("sk_a", 1'b0, 1'b0, 1'b1, 64'h50, 1'b0, 1'b1, 64'h50, 1'b1);
    step("sk_b", 1'b0, 1'b0, 1'b1, 64'h51, 1'b0, 1'b1, 64'h50, 1'b0);
    step("sk_c", 1'b0, 1'b0, 1'b0, 64'h0,  1'b1, 1'b1, 64'h51, 1'b1);
    step("sk_d", 1'b0, 1'b0, 1'b0, 64'h0,  1'b1, 1'b0, 64'h51, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
